tf_exp_gen: RTL and testbench
=============================

// Module: tf_exp_gen
// PURPOSE
//  Twiddle-exponent sequencer for the radix-2 in-place FFT datapath. Walks all
//  LOG2N stages, 8 butterflies per cycle, and issues one 12-bit twiddle exponent
//  per lane (EXP0..EXP7). These exponents drive the address inputs of the
//  downstream twiddle ROM bank (1-cycle registered read, 64-bit TF words).
//  Also supplies stage/beat sideband and a valid flag aligned to the ROM output.
// PARAMETERS
//  LOG2N   13  log2 of FFT size; N/2 = 4096 butterflies/stage, EXP width LOG2N-1
//  LANES    8  butterflies issued per cycle (fixed; lane index is 3 bits)
// PORTS
//  CLK        in   1   clock, rising edge
//  RSTn       in   1   asynchronous active-low reset
//  START      in   1   1-cycle pulse, begins a full LOG2N-stage sweep (IDLE only)
//  HOLD       in   1   downstream stall; freezes sequencing while high
//  EXP0..EXP7 out  12  per-lane twiddle exponent (registered)
//  EXP_VALID  out  1   EXP0..7 valid this cycle
//  STAGE      out  4   stage index of current EXP beat, 0..LOG2N-1
//  LAST       out  1   current EXP beat is final beat of final stage
//  TF_VALID   out  1   EXP_VALID delayed 1 cycle (aligns with ROM Q)
//  BUSY       out  1   high from accepted START until DONE
//  DONE       out  1   1-cycle pulse after final beat issued
// BEHAVIOUR
//  Reset (RSTn=0, async): FSM=IDLE; cnt=0, stg=0; all outputs 0.
//  FSM: IDLE -START-> RUN; RUN -(issue of last beat)-> FIN; FIN -> IDLE.
//   START outside IDLE is ignored. START and HOLD in the same cycle: START
//   accepted; first beat waits for HOLD low.
//  Counters: cnt 9 bits (0..511 beats/stage), stg 4 bits (0..LOG2N-1).
//  In RUN with HOLD=0, each cycle issues one beat (regs update next edge):
//   j_k  = {cnt, k[2:0]}  (12-bit butterfly index, lane k=0..7)
//   mask = (1<<stg)-1 ; EXPk = (j_k & mask) << (LOG2N-1-stg), truncated to 12b
//   EXP_VALID=1, STAGE=stg, LAST=(stg==LOG2N-1 && cnt==511)
//   cnt++; cnt wraps 511->0 and stg++ on wrap. Last beat -> FIN, counters clear.
//  HOLD=1 in RUN: counters frozen, EXP0..7/STAGE/LAST keep previous values,
//   EXP_VALID=0. No beat lost or duplicated across any HOLD pattern.
//  FIN: DONE=1 for exactly one cycle, BUSY drops with it (BUSY=0 during FIN).
//  TF_VALID = EXP_VALID registered once (independent of HOLD).
//  Latency: START edge -> first EXP_VALID=1 one cycle later (HOLD=0).
//  Total: LOG2N*512 = 6656 valid beats per sweep; sweep = 6656 cycles + FIN.
//  Stage 0 exponents all 0; last stage EXPk = j_k (full 0..4095 range).
//  Reset mid-sweep: immediate return to IDLE state/outputs, no DONE pulse.
// TESTING
//  T1 RSTn low, then START: cycle 1 EXP0..7=0, STAGE=0, EXP_VALID=1; 512 beats
//     of zeros, then STAGE=1.
//  T2 Stage 1 beats: EXP = 0,2048,0,2048,0,2048,0,2048 every beat; stage 2
//     first beat: 0,1024,2048,3072,0,1024,2048,3072.
//  T3 Stage 12 first beat EXP=0..7, last beat EXP=4088..4095 with LAST=1;
//     next cycle DONE=1, BUSY=0; total EXP_VALID count = 6656.
//  T4 Random HOLD (~30%) over full sweep: captured exponent stream identical
//     to T1-T3 HOLD-free stream; TF_VALID equals EXP_VALID shifted by 1.
//  T5 START pulsed at beat 100 of stage 3: ignored, sequence unaffected,
//     single DONE at end.
//  T6 RSTn asserted at stage 5 beat 37: outputs 0 asynchronously, no DONE;
//     new START restarts at stage 0 beat 0.

Source files
------------

// File: rtl/tf_exp_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : tf_exp_gen_if
//  Purpose  : Bundles the control inputs and the per-lane exponent outputs
//             of the twiddle-exponent sequencer.
//  Signals  : start     - 1-cycle pulse, begins a full sweep
//             hold      - downstream stall, freezes sequencing
//             exp       - LANES x (LOG2N-1) per-lane twiddle exponents
//             exp_valid - exp valid this cycle
//             stage     - stage index of the current beat
//             last      - final beat of final stage
//             tf_valid  - exp_valid delayed one cycle (aligned to ROM Q)
//             busy      - sweep in progress
//             done      - 1-cycle pulse after the final beat
//  Modports : master = sequencer side, slave = consumer / stimulus side
//  Revision : 1.0  initial release
// ============================================================================
interface tf_exp_gen_if #(
   parameter int LOG2N = 13,
   parameter int LANES = 8
);
   logic                            start;
   logic                            hold;
   logic [LANES-1:0][LOG2N-2:0]     exp;
   logic                            exp_valid;
   logic [3:0]                      stage;
   logic                            last;
   logic                            tf_valid;
   logic                            busy;
   logic                            done;

   modport master (
      input  start, hold,
      output exp, exp_valid, stage, last, tf_valid, busy, done
   );

   modport slave (
      output start, hold,
      input  exp, exp_valid, stage, last, tf_valid, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/tf_exp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tf_exp_gen
//  Purpose  : Twiddle-exponent sequencer for a radix-2 in-place FFT. Walks
//             all LOG2N stages, LANES butterflies per cycle, and issues one
//             (LOG2N-1)-bit twiddle exponent per lane for the twiddle ROM.
//  Ports    : clk   - clock, rising edge
//             rst_n - asynchronous active-low reset
//             bus   - tf_exp_gen_if.master (start/hold in; exponents,
//                     exp_valid, stage, last, tf_valid, busy, done out)
//  Revision : 1.0  initial release
// ============================================================================
module tf_exp_gen #(
   parameter int LOG2N = 13,
   parameter int LANES = 8
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   tf_exp_gen_if.master    bus
);

   localparam int c_EW = LOG2N - 1;     // exponent / butterfly-index width
   localparam int c_LW = 3;             // lane index width (8 lanes)
   localparam int c_CW = c_EW - c_LW;   // beat counter width

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_RUN  = 2'd1;
   localparam logic [1:0] c_S_FIN  = 2'd2;

   logic [1:0]                  r_state;
   logic [1:0]                  w_next;
   logic [c_CW-1:0]             r_cnt;
   logic [3:0]                  r_stg;
   logic [LANES-1:0][c_EW-1:0]  r_exp;
   logic [LANES-1:0][c_EW-1:0]  w_exp;
   logic                        r_exp_valid;
   logic [3:0]                  r_stage;
   logic                        r_last;
   logic                        r_tf_valid;
   logic                        r_done;
   logic                        w_busy;
   logic                        w_fin;
   logic                        w_issue;
   logic                        w_final;
   logic [c_EW-1:0]             w_mask;
   logic [3:0]                  w_sh;

   assign w_issue = (r_state == c_S_RUN) && !bus.hold;
   assign w_final = (r_stg == 4'(LOG2N-1)) && (r_cnt == '1);

   // At the final stage the shift pushes the 1 out of range, so the
   // subtraction wraps to all-ones: the full index passes through.
   assign w_mask  = (c_EW'(1) << r_stg) - c_EW'(1);
   assign w_sh    = 4'(c_EW) - r_stg;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= c_S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_S_IDLE: if (bus.start)         w_next = c_S_RUN;
         c_S_RUN:  if (w_issue && w_final) w_next = c_S_FIN;
         c_S_FIN:                          w_next = c_S_IDLE;
         default:                          w_next = c_S_IDLE;
      endcase
   end

   // FIN is entered on the same edge that presents the last beat, so busy
   // covers it and the done pulse is registered to trail the LAST beat.
   always_comb begin
      w_busy = (r_state != c_S_IDLE);
      w_fin  = (r_state == c_S_FIN);
   end

   // ------------------------------------------------------ lane exponents
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [c_EW-1:0] w_j;
      assign w_j      = {r_cnt, c_LW'(k)};
      assign w_exp[k] = (w_j & w_mask) << w_sh;
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_stg       <= '0;
         r_exp       <= '0;
         r_exp_valid <= 1'b0;
         r_stage     <= '0;
         r_last      <= 1'b0;
         r_tf_valid  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_tf_valid  <= r_exp_valid;
         r_done      <= w_fin;
         r_exp_valid <= w_issue;
         if (w_issue) begin
            r_exp   <= w_exp;
            r_stage <= r_stg;
            r_last  <= w_final;
            if (w_final) begin
               r_cnt <= '0;
               r_stg <= '0;
            end else begin
               r_cnt <= r_cnt + c_CW'(1);
               if (r_cnt == '1) r_stg <= r_stg + 4'd1;
            end
         end
      end
   end

   assign bus.exp       = r_exp;
   assign bus.exp_valid = r_exp_valid;
   assign bus.stage     = r_stage;
   assign bus.last      = r_last;
   assign bus.tf_valid  = r_tf_valid;
   assign bus.busy      = w_busy;
   assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tf_exp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tf_exp_gen
//  Purpose  : Self-checking bench for tf_exp_gen. Each accepted START pushes
//             the full expected beat stream into a queue; a negedge monitor
//             pops and compares whenever exp_valid is high.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tf_exp_gen;
   localparam int LOG2N = 13;
   localparam int LANES = 8;
   localparam int BEATS = 512;
   localparam int TOTAL = LOG2N * BEATS;

   typedef struct packed {
      logic [LANES-1:0][LOG2N-2:0] e;
      logic [3:0]                  s;
      logic                        l;
   } beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tf_exp_gen_if #(.LOG2N(LOG2N), .LANES(LANES)) bus ();
   tf_exp_gen #(.LOG2N(LOG2N), .LANES(LANES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   beat_t exp_q[$];
   beat_t mt;
   int    checks   = 0;
   int    failures = 0;
   int    n_beats  = 0;
   int    n_done   = 0;
   logic  prev_valid = 1'b0;
   logic  prev_vl    = 1'b0;

   // Reference: butterfly j = beat*8+lane; its twiddle exponent in stage s is
   // (j mod 2^s) scaled by 2^(LOG2N-1-s).
   function automatic beat_t model(input int s, input int b);
      beat_t t;
      t.s = 4'(s);
      t.l = (s == LOG2N-1) && (b == BEATS-1);
      for (int k = 0; k < LANES; k++) begin
         int j;
         j = b * LANES + k;
         t.e[k] = 12'((j % (1 << s)) * (1 << (LOG2N-1-s)));
      end
      return t;
   endfunction

   task automatic push_sweep();
      for (int s = 0; s < LOG2N; s++)
         for (int b = 0; b < BEATS; b++)
            exp_q.push_back(model(s, b));
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic check_zero(input string tag);
      for (int k = 0; k < LANES; k++)
         check($sformatf("%s_exp%0d", tag, k), 32'(bus.exp[k]), 0);
      check({tag, "_exp_valid"}, 32'(bus.exp_valid), 0);
      check({tag, "_stage"},     32'(bus.stage),     0);
      check({tag, "_last"},      32'(bus.last),      0);
      check({tag, "_tf_valid"},  32'(bus.tf_valid),  0);
      check({tag, "_busy"},      32'(bus.busy),      0);
      check({tag, "_done"},      32'(bus.done),      0);
   endtask

   // --------------------------------------------------------- monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_vl    = 1'b0;
      end else begin
         checks++;
         if (bus.tf_valid !== prev_valid) begin
            failures++;
            $display("FAIL tf_valid got=%0b required=%0b", bus.tf_valid, prev_valid);
         end
         if (bus.done || prev_vl) begin
            checks++;
            if (bus.done !== prev_vl) begin
               failures++;
               $display("FAIL done_timing got=%0b required=%0b", bus.done, prev_vl);
            end
         end
         if (bus.done) begin
            n_done++;
            checks++;
            if (bus.busy !== 1'b0) begin
               failures++;
               $display("FAIL busy_at_done got=%0b required=0", bus.busy);
            end
         end
         if (bus.exp_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_beat got stage=%0d required=no beat", bus.stage);
            end else begin
               mt = exp_q.pop_front();
               if ({bus.exp, bus.stage, bus.last} !== mt) begin
                  failures++;
                  $display("FAIL beat n=%0d got exp=%h stg=%0d last=%0b required exp=%h stg=%0d last=%0b",
                           n_beats, bus.exp, bus.stage, bus.last, mt.e, mt.s, mt.l);
               end
            end
            if (bus.last) begin
               checks++;
               if (bus.busy !== 1'b1) begin
                  failures++;
                  $display("FAIL busy_at_last got=%0b required=1", bus.busy);
               end
            end
            n_beats++;
         end
         prev_valid = bus.exp_valid;
         prev_vl    = bus.exp_valid && bus.last;
      end
   end

   // ---------------------------------------------------------- driver
   task automatic sweep(input bit rh, input bit hold_at_start, input bit inj_start, input int rst_at);
      int bb, bd, cyc;
      bit injected, aborted;
      injected = 0;
      aborted  = 0;
      bb = n_beats;
      bd = n_done;
      push_sweep();
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.hold  = hold_at_start;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_after_start", 32'(bus.busy), 1);
      check("valid_not_yet", 32'(bus.exp_valid), 0);
      if (hold_at_start) begin
         repeat (3) begin
            @(posedge clk); #1;
            check("held_no_issue", 32'(bus.exp_valid), 0);
         end
         bus.hold = 1'b0;
      end else begin
         @(posedge clk); #1;
         check("first_beat_latency", 32'(bus.exp_valid), 1);
      end
      cyc = 0;
      while (n_done == bd && !aborted && cyc < 40000) begin
         @(posedge clk); #1;
         cyc++;
         bus.start = 1'b0;
         bus.hold  = rh ? ($urandom_range(0, 99) < 30) : 1'b0;
         if (inj_start && !injected && (n_beats - bb == 3*BEATS + 100)) begin
            bus.start = 1'b1;
            injected  = 1;
         end
         if (rst_at > 0 && (n_beats - bb == rst_at)) begin
            #2 rst_n = 1'b0;
            #1 check_zero("async_rst");
            exp_q.delete();
            aborted = 1;
         end
      end
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      if (cyc >= 40000) begin
         failures++;
         $display("FAIL sweep_timeout got=%0d beats required=%0d", n_beats - bb, TOTAL);
      end
      if (aborted) begin
         repeat (3) @(posedge clk);
         #1;
         check("no_done_after_reset", 32'(n_done - bd), 0);
         rst_n = 1'b1;
      end else begin
         repeat (4) @(posedge clk);
         #1;
         check("beat_total", 32'(n_beats - bb), TOTAL);
         check("single_done", 32'(n_done - bd), 1);
         check("queue_drained", 32'(exp_q.size()), 0);
         check("idle_busy", 32'(bus.busy), 0);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      rst_n     = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_zero("idle");
      sweep(0, 0, 0, 0);               // hold-free sweep
      sweep(1, 0, 0, 0);               // random hold
      sweep(1, 1, 1, 0);               // start with hold, stray start mid-sweep
      sweep(1, 0, 0, 5*BEATS + 37);    // reset mid-sweep
      sweep(0, 0, 0, 0);               // clean restart
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
